// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine.
// A block is captured on the accepting edge, then COLS_PER_CYCLE columns are
// transformed per clock for N = 4/COLS_PER_CYCLE cycles. The result is held
// in DONE until the consumer takes it. A new block may be accepted on the same
// edge as the handoff, so blocks can be issued every N+1 cycles.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode,
    output logic         busy
);

    localparam int N     = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Only 1, 2 or 4 columns per cycle divide the state evenly.
    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       data_q, data_d;
    logic [127:0]       result_q, result_d;
    logic               mode_q, mode_d;
    logic [31:0]        col_in  [COLS_PER_CYCLE];
    logic [31:0]        col_out [COLS_PER_CYCLE];

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the circulant matrix; inv selects {0E,0B,0D,09}
    // instead of {02,03,01,01}. Products are built from x, 2x, 4x, 8x.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a   [4];
        logic [7:0] p   [4][4];
        logic [7:0] r   [4];
        logic [7:0] x2, x4, x8;
        logic [1:0] k;
        for (int j = 0; j < 4; j++) begin
            a[j] = col[31 - 8*j -: 8];
        end
        for (int j = 0; j < 4; j++) begin
            x2 = xtime(a[j]);
            x4 = xtime(x2);
            x8 = xtime(x4);
            if (!inv) begin
                p[j][0] = x2;
                p[j][1] = x2 ^ a[j];
                p[j][2] = a[j];
                p[j][3] = a[j];
            end else begin
                p[j][0] = x8 ^ x4 ^ x2;
                p[j][1] = x8 ^ x2 ^ a[j];
                p[j][2] = x8 ^ x4 ^ a[j];
                p[j][3] = x8 ^ a[j];
            end
        end
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                k    = 2'(j - i);
                r[i] = r[i] ^ p[j][k];
            end
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    // Pick the columns of the current group out of the captured state.
    always_comb begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_in[g] = data_q[127 - 32*(int'(cnt_q)*COLS_PER_CYCLE + g) -: 32];
        end
    end

    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
            assign col_out[gi] = mix_col(col_in[gi], mode_q);
        end
    endgenerate

    // Next-state, capture, result write-back and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        mode_d    = mode_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    result_d[127 - 32*(int'(cnt_q)*COLS_PER_CYCLE + g) -: 32] = col_out[g];
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        data_d  = in_data;
                        mode_d  = in_mode;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

    assign out_data = result_q;
    assign out_mode = mode_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: three instances (1, 2, 4 columns per
// cycle) checked against a table of known AES MixColumns vectors, plus
// sequences for streaming, backpressure, input toggling and mid-run reset.
module tb_mix_columns_engine;

    typedef struct {
        logic         mode;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_mode   [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         out_mode  [3];
    logic         busy      [3];

    vec_t vecs [4];
    int   checks;
    int   failures;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mix_columns_engine #(.COLS_PER_CYCLE(1 << gi)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .in_mode   (in_mode[gi]),
                .in_data   (in_data[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .out_data  (out_data[gi]),
                .out_mode  (out_mode[gi]),
                .busy      (busy[gi])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on instance k with table vector v.
    task automatic run_txn(input int k, input int v);
        int lat;
        lat = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = vecs[v].din;
        in_mode[k]  = vecs[v].mode;
        chk("in_ready_idle", 128'(in_ready[k]), 128'(1));
        tick;
        in_valid[k] = 1'b0;
        in_data[k]  = '0;
        in_mode[k]  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (out_valid[k]) begin
                lat = i;
                break;
            end
        end
        chk("latency", 128'(lat), 128'(4 >> k));
        chk("out_data", out_data[k], vecs[v].dout);
        chk("out_mode", 128'(out_mode[k]), 128'(vecs[v].mode));
        chk("busy_done", 128'(busy[k]), 128'(1));
        out_ready[k] = 1'b1;
        tick;
        out_ready[k] = 1'b0;
        chk("out_valid_drop", 128'(out_valid[k]), 128'(0));
        chk("busy_idle", 128'(busy[k]), 128'(0));
        $display("txn cols=%0d mode=%0d in=%h out=%h latency=%0d", 1 << k, vecs[v].mode,
                 vecs[v].din, out_data[k], lat);
    endtask

    initial begin
        logic acc;
        int   nsent, nrecv, last;
        int   seen;

        checks   = 0;
        failures = 0;

        // Forward vectors and their inverses (FIPS-197 / well-known columns).
        vecs[0] = '{1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6,
                          128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vecs[1] = '{1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                          128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[2] = '{1'b0, 128'hd4d4d4d5_2d26314c_d4d4d4d5_2d26314c,
                          128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8};
        vecs[3] = '{1'b1, 128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8,
                          128'hd4d4d4d5_2d26314c_d4d4d4d5_2d26314c};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_mode[k]   = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 128'(in_ready[k]), 128'(1));
            chk("rst_out_valid", 128'(out_valid[k]), 128'(0));
            chk("rst_out_data", out_data[k], 128'(0));
            chk("rst_out_mode", 128'(out_mode[k]), 128'(0));
            chk("rst_busy", 128'(busy[k]), 128'(0));
        end
        rst_n = 1'b1;
        tick;

        // Table vectors on every column width.
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 4; v++) begin
                run_txn(k, v);
            end
        end

        // Back-to-back stream of 8 alternating-mode blocks, out_ready held high.
        nsent = 0;
        nrecv = 0;
        last  = -1;
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = vecs[0].din;
        in_mode[0]   = vecs[0].mode;
        for (int t = 0; t < 120 && nrecv < 8; t++) begin
            acc = in_valid[0] && in_ready[0];
            if (out_valid[0]) begin
                chk("b2b_data", out_data[0], vecs[nrecv % 4].dout);
                chk("b2b_mode", 128'(out_mode[0]), 128'(vecs[nrecv % 4].mode));
                chk("b2b_in_ready", 128'(in_ready[0]), 128'(1));
                if (last >= 0) chk("b2b_spacing", 128'(t - last), 128'(5));
                $display("txn b2b block=%0d mode=%0d out=%h cycle=%0d", nrecv,
                         out_mode[0], out_data[0], t);
                last = t;
                nrecv++;
            end
            tick;
            if (acc) begin
                nsent++;
                if (nsent < 8) begin
                    in_data[0] = vecs[nsent % 4].din;
                    in_mode[0] = vecs[nsent % 4].mode;
                end else begin
                    in_valid[0] = 1'b0;
                end
            end
        end
        chk("b2b_count", 128'(nrecv), 128'(8));
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        tick;

        // Backpressure: hold the result for 10 cycles while a new block is offered.
        in_valid[0] = 1'b1;
        in_data[0]  = vecs[1].din;
        in_mode[0]  = vecs[1].mode;
        tick;
        in_valid[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (out_valid[0]) begin
                seen = 1;
                break;
            end
        end
        chk("bp_reached_done", 128'(seen), 128'(1));
        in_valid[0] = 1'b1;
        in_data[0]  = vecs[2].din;
        in_mode[0]  = vecs[2].mode;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
            chk("bp_out_data", out_data[0], vecs[1].dout);
            chk("bp_out_mode", 128'(out_mode[0]), 128'(1));
            chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
            tick;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        tick;
        out_ready[0] = 1'b0;
        chk("bp_drop_valid", 128'(out_valid[0]), 128'(0));
        chk("bp_not_accepted", 128'(busy[0]), 128'(0));
        $display("txn backpressure out=%h", vecs[1].dout);

        // Inputs toggled every cycle while running must not affect the result.
        in_valid[0] = 1'b1;
        in_data[0]  = vecs[3].din;
        in_mode[0]  = vecs[3].mode;
        tick;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            in_mode[0] = ~in_mode[0];
            in_data[0] = {$urandom, $urandom, $urandom, $urandom};
            tick;
            if (out_valid[0]) begin
                seen = 1;
                break;
            end
        end
        in_valid[0] = 1'b0;
        chk("tog_reached_done", 128'(seen), 128'(1));
        chk("tog_out_data", out_data[0], vecs[3].dout);
        chk("tog_out_mode", 128'(out_mode[0]), 128'(1));
        out_ready[0] = 1'b1;
        tick;
        out_ready[0] = 1'b0;
        chk("tog_drop_valid", 128'(out_valid[0]), 128'(0));
        $display("txn toggle out=%h", vecs[3].dout);

        // Reset pulse in the second RUN cycle aborts the block.
        in_valid[0] = 1'b1;
        in_data[0]  = vecs[1].din;
        in_mode[0]  = vecs[1].mode;
        tick;
        in_valid[0] = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 128'(in_ready[0]), 128'(1));
        chk("mrst_out_valid", 128'(out_valid[0]), 128'(0));
        chk("mrst_out_data", out_data[0], 128'(0));
        chk("mrst_out_mode", 128'(out_mode[0]), 128'(0));
        chk("mrst_busy", 128'(busy[0]), 128'(0));
        tick;
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (out_valid[0] || busy[0]) seen = 1;
        end
        chk("mrst_no_valid_after", 128'(seen), 128'(0));
        $display("txn reset abort");
        run_txn(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
